// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the serial-LCD responder: command codes, decoder
// states, parameter targets and the window-wrap helper.
// Optional feature macro used by this block: LCD_SPI_RX_SYNC_EN (input synchronizers).
package lcd_spi_pkg;

  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PARAM,
    ST_RAMWR_HI,
    ST_RAMWR_LO
  } dec_state_t;

  typedef enum logic [1:0] {
    TGT_COL,
    TGT_ROW,
    TGT_SKIP
  } param_tgt_t;

  // Equality-only wrap: an inverted window (start > end) runs up to 255
  // and then returns to the start, rather than comparing with '<'.
  function automatic logic win_wrap(input logic [7:0] cur, input logic [7:0] last);
    return (cur == last) || (cur == 8'hFF);
  endfunction

endpackage

// File: rtl/lcd_spi_rx_shift.sv
// Input stage + byte assembler: stages SCL/SDA/DC/RES/CS, detects SCL rises,
// shifts SDA MSB first and pulses o_byte_vld when 8 bits are collected.
// Ports: i_clk/i_rst (async high), pad inputs i_*, outputs o_byte_vld/o_byte_dat/
// o_byte_dc and o_soft_rst (staged RES asserted). Macro: LCD_SPI_RX_SYNC_EN.
module lcd_spi_rx_shift (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  input  logic       i_dc,
  input  logic       i_res_n,
  input  logic       i_cs_n,
  output logic       o_byte_vld,
  output logic [7:0] o_byte_dat,
  output logic       o_byte_dc,
  output logic       o_soft_rst
);

  // Bundle order: {scl, sda, dc, res_n, cs_n}; idle pads are RES/CS high.
  localparam logic [4:0] PAD_IDLE = 5'b00011;

  logic [4:0] w_stage;
  logic       w_scl, w_sda, w_dc, w_res_n, w_cs_n, w_rise;

`ifdef LCD_SPI_RX_SYNC_EN
  logic [4:0] r_sync1, r_sync2;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= PAD_IDLE;
      r_sync2 <= PAD_IDLE;
    end else begin
      r_sync1 <= {i_scl, i_sda, i_dc, i_res_n, i_cs_n};
      r_sync2 <= r_sync1;
    end
  end
  assign w_stage = r_sync2;
`else
  assign w_stage = {i_scl, i_sda, i_dc, i_res_n, i_cs_n};
`endif

  assign {w_scl, w_sda, w_dc, w_res_n, w_cs_n} = w_stage;

  logic       r_scl_d;
  logic [6:0] r_shift;
  logic [2:0] r_cnt;
  logic       r_dc;
  logic       r_byte_vld;
  logic [7:0] r_byte_dat;
  logic       r_byte_dc;

  assign w_rise = w_scl & ~r_scl_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_d    <= 1'b0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_dc       <= 1'b0;
      r_byte_vld <= 1'b0;
      r_byte_dat <= '0;
      r_byte_dc  <= 1'b0;
    end else begin
      r_scl_d    <= w_scl;
      r_byte_vld <= 1'b0;
      if (!w_res_n) begin
        r_shift    <= '0;
        r_cnt      <= '0;
        r_dc       <= 1'b0;
        r_byte_dat <= '0;
        r_byte_dc  <= 1'b0;
      end else if (w_cs_n) begin
        // Deselect drops any partial byte; the old shift bits are simply overwritten.
        r_cnt <= '0;
      end else if (w_rise) begin
        r_shift <= {r_shift[5:0], w_sda};
        r_cnt   <= r_cnt + 3'd1;
        if (r_cnt == 3'd0) r_dc <= w_dc;
        if (r_cnt == 3'd7) begin
          r_byte_vld <= 1'b1;
          r_byte_dat <= {r_shift, w_sda};
          r_byte_dc  <= r_dc;
        end
      end
    end
  end

  assign o_byte_vld = r_byte_vld;
  assign o_byte_dat = r_byte_dat;
  assign o_byte_dc  = r_byte_dc;
  assign o_soft_rst = ~w_res_n;

endmodule

// File: rtl/lcd_spi_rx.sv
// ST7735-style SPI write-stream decoder: tracks CASET/RASET window and RAMWR
// pixel stream, emitting one pix_we per on-screen RGB565 pixel.
// Ports: clk, rst_in (async high), lcd_* pads in; byte_*, pix_*, disp_on,
// sleep_out, err_stray out. Macro: LCD_SPI_RX_SYNC_EN (pad synchronizers).
module lcd_spi_rx
  import lcd_spi_pkg::*;
#(
  parameter int LCD_W = 132,
  parameter int LCD_H = 162
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        lcd_clk_in,
  input  logic        lcd_data_in,
  input  logic        lcd_dc_in,
  input  logic        lcd_rst_n_in,
  input  logic        lcd_cs_n_in,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        pix_we,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        disp_on,
  output logic        sleep_out,
  output logic        err_stray
);

  localparam logic [8:0] W_LIM  = 9'(LCD_W);
  localparam logic [8:0] H_LIM  = 9'(LCD_H);
  localparam logic [7:0] XE_RST = 8'(LCD_W - 1);
  localparam logic [7:0] YE_RST = 8'(LCD_H - 1);

  logic       w_byte_vld, w_byte_dc, w_soft_rst;
  logic [7:0] w_byte_dat;

  lcd_spi_rx_shift u_shift (
    .i_clk      (clk),
    .i_rst      (rst_in),
    .i_scl      (lcd_clk_in),
    .i_sda      (lcd_data_in),
    .i_dc       (lcd_dc_in),
    .i_res_n    (lcd_rst_n_in),
    .i_cs_n     (lcd_cs_n_in),
    .o_byte_vld (w_byte_vld),
    .o_byte_dat (w_byte_dat),
    .o_byte_dc  (w_byte_dc),
    .o_soft_rst (w_soft_rst)
  );

  assign byte_valid = w_byte_vld;
  assign byte_data  = w_byte_dat;
  assign byte_dc    = w_byte_dc;

  dec_state_t r_state, w_state;
  param_tgt_t r_tgt,   w_tgt;
  logic [1:0] r_pcnt,  w_pcnt;
  logic [7:0] r_xs, r_xe, r_ys, r_ye, r_x, r_y, r_hi;
  logic [7:0] w_xs, w_xe, w_ys, w_ye, w_x, w_y, w_hi;
  logic       r_pix_we, w_pix_we, r_err, w_err, r_disp, w_disp, r_sleep, w_sleep;
  logic [7:0] r_pix_x, w_pix_x, r_pix_y, w_pix_y;
  logic [15:0] r_pix_dat, w_pix_dat;

  always_comb begin
    w_state = r_state;  w_tgt = r_tgt;  w_pcnt = r_pcnt;
    w_xs = r_xs;  w_xe = r_xe;  w_ys = r_ys;  w_ye = r_ye;
    w_x = r_x;    w_y = r_y;    w_hi = r_hi;
    w_pix_we = 1'b0;  w_err = 1'b0;
    w_pix_x = r_pix_x;  w_pix_y = r_pix_y;  w_pix_dat = r_pix_dat;
    w_disp = r_disp;    w_sleep = r_sleep;

    if (w_byte_vld) begin
      if (!w_byte_dc) begin
        // A command byte restarts decoding from any state.
        w_state = ST_IDLE;
        w_pcnt  = 2'd0;
        case (w_byte_dat)
          CMD_CASET:   begin w_state = ST_PARAM; w_tgt = TGT_COL; end
          CMD_RASET:   begin w_state = ST_PARAM; w_tgt = TGT_ROW; end
          CMD_RAMWR:   begin w_x = r_xs; w_y = r_ys; w_state = ST_RAMWR_HI; end
          CMD_SLPOUT:  w_sleep = 1'b1;
          CMD_SLPIN:   w_sleep = 1'b0;
          CMD_DISPON:  w_disp  = 1'b1;
          CMD_DISPOFF: w_disp  = 1'b0;
          default:     begin w_state = ST_PARAM; w_tgt = TGT_SKIP; end
        endcase
      end else begin
        case (r_state)
          ST_IDLE: w_err = 1'b1;
          ST_PARAM: begin
            w_pcnt = r_pcnt + 2'd1;
            // Parameters 0 and 2 are the (unused) high bytes of start/end.
            if (r_tgt == TGT_COL) begin
              if (r_pcnt == 2'd1) w_xs = w_byte_dat;
              if (r_pcnt == 2'd3) begin w_xe = w_byte_dat; w_state = ST_IDLE; end
            end else if (r_tgt == TGT_ROW) begin
              if (r_pcnt == 2'd1) w_ys = w_byte_dat;
              if (r_pcnt == 2'd3) begin w_ye = w_byte_dat; w_state = ST_IDLE; end
            end
          end
          ST_RAMWR_HI: begin
            w_hi    = w_byte_dat;
            w_state = ST_RAMWR_LO;
          end
          ST_RAMWR_LO: begin
            w_pix_dat = {r_hi, w_byte_dat};
            w_pix_x   = r_x;
            w_pix_y   = r_y;
            w_pix_we  = ({1'b0, r_x} < W_LIM) && ({1'b0, r_y} < H_LIM);
            if (win_wrap(r_x, r_xe)) begin
              w_x = r_xs;
              w_y = win_wrap(r_y, r_ye) ? r_ys : r_y + 8'd1;
            end else begin
              w_x = r_x + 8'd1;
            end
            w_state = ST_RAMWR_HI;
          end
          default: w_state = ST_IDLE;
        endcase
      end
    end

    // Panel RES behaves exactly like rst_in, one clock late.
    if (w_soft_rst) begin
      w_state = ST_IDLE;  w_tgt = TGT_COL;  w_pcnt = 2'd0;
      w_xs = 8'd0;  w_xe = XE_RST;  w_ys = 8'd0;  w_ye = YE_RST;
      w_x = 8'd0;   w_y = 8'd0;     w_hi = 8'd0;
      w_pix_we = 1'b0;  w_err = 1'b0;
      w_pix_x = 8'd0;   w_pix_y = 8'd0;  w_pix_dat = 16'd0;
      w_disp = 1'b0;    w_sleep = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;  r_tgt <= TGT_COL;  r_pcnt <= 2'd0;
      r_xs <= 8'd0;  r_xe <= XE_RST;  r_ys <= 8'd0;  r_ye <= YE_RST;
      r_x <= 8'd0;   r_y <= 8'd0;     r_hi <= 8'd0;
      r_pix_we <= 1'b0;  r_err <= 1'b0;
      r_pix_x <= 8'd0;   r_pix_y <= 8'd0;  r_pix_dat <= 16'd0;
      r_disp <= 1'b0;    r_sleep <= 1'b0;
    end else begin
      r_state <= w_state;  r_tgt <= w_tgt;  r_pcnt <= w_pcnt;
      r_xs <= w_xs;  r_xe <= w_xe;  r_ys <= w_ys;  r_ye <= w_ye;
      r_x <= w_x;    r_y <= w_y;    r_hi <= w_hi;
      r_pix_we <= w_pix_we;  r_err <= w_err;
      r_pix_x <= w_pix_x;    r_pix_y <= w_pix_y;  r_pix_dat <= w_pix_dat;
      r_disp <= w_disp;      r_sleep <= w_sleep;
    end
  end

  assign pix_we    = r_pix_we;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_data  = r_pix_dat;
  assign disp_on   = r_disp;
  assign sleep_out = r_sleep;
  assign err_stray = r_err;

endmodule
